prince_sched: RTL and testbench

//  Shares one round-based PRINCE core (pcore) between NREQ requesters: round-robin arbitration,

---
 rtl/prince_pkg.sv | 16 +
 rtl/prince_sched_rr_arb.sv | 35 +++
 rtl/prince_sched.sv | 109 ++++++++++
 tb/tb_prince_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_pkg.sv
// Shared PRINCE scheduler definitions: block/key widths, default core latency
// and the scheduler state encoding.
package prince_pkg;

  localparam int unsigned PRINCE_BLK = 64;
  localparam int unsigned PRINCE_KEY = 128;
  localparam int unsigned PRINCE_LAT = 12;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/prince_sched_rr_arb.sv
// rr_arb: picks one of NREQ requests, round-robin from ptr.
// PRINCE_SCHED_PRIO_EN selects fixed priority (lowest index wins, ptr ignored).
module rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef PRINCE_SCHED_PRIO_EN
      cand = IDW'(i);
`else
      cand = IDW'((32'(ptr) + i) % NREQ);
`endif
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/prince_sched.sv
// prince_sched: shares one round-based PRINCE core between NREQ requesters.
// Define PRINCE_SCHED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module prince_sched
  import prince_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = PRINCE_LAT,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            rdec,
  input  logic [NREQ*PRINCE_BLK-1:0] rdat,
  input  logic [NREQ*PRINCE_KEY-1:0] rkey,
  output logic [NREQ-1:0]            gnt,
  output logic                       rsp_vld,
  output logic [IDW-1:0]             rsp_id,
  output logic [PRINCE_BLK-1:0]      rsp_dat,
  input  logic                       rsp_rdy,
  output logic                       st,
  output logic                       d,
  output logic [PRINCE_BLK-1:0]      inp,
  output logic [PRINCE_KEY-1:0]      key,
  input  logic [PRINCE_BLK-1:0]      cout
);

  localparam int unsigned CW = $clog2(LAT + 1);

  sched_state_t   state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [NREQ-1:0] arb_gnt;
  logic           arb_any;
  logic [CW-1:0]  cnt;

  rr_arb #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(win),
    .any(arb_any)
  );

  // Grant is combinational so the winner's data is sampled on the same edge.
  always_comb begin
    gnt = '0;
    if (state == IDLE && !rst) gnt = arb_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      st      <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_dat <= '0;
      d       <= 1'b0;
      inp     <= '0;
      key     <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            d      <= rdec[win];
            inp    <= rdat[PRINCE_BLK*win +: PRINCE_BLK];
            key    <= rkey[PRINCE_KEY*win +: PRINCE_KEY];
            rsp_id <= win;
`ifdef PRINCE_SCHED_PRIO_EN
            ptr    <= '0;
`else
            ptr    <= (32'(win) == NREQ - 1) ? '0 : win + IDW'(1);
`endif
            st     <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          st    <= 1'b0;
          cnt   <= CW'(1);
          state <= RUN;
        end
        RUN: begin
          if (32'(cnt) == LAT) begin
            rsp_dat <= cout;
            rsp_vld <= 1'b1;
            cnt     <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prince_sched.sv
// Directed bench for prince_sched with a behavioural PRINCE core attached.
module tb_prince_sched;
  import prince_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 12;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   rdec;
  logic [NREQ*64-1:0]  rdat;
  logic [NREQ*128-1:0] rkey;
  logic [NREQ-1:0]   gnt;
  logic              rsp_vld;
  logic [IDW-1:0]    rsp_id;
  logic [63:0]       rsp_dat;
  logic              rsp_rdy;
  logic              st;
  logic              d;
  logic [63:0]       inp;
  logic [127:0]      key;
  logic [63:0]       cout;

  int unsigned n_run;
  int unsigned n_fail;

  always #5 clk = ~clk;

  prince_sched #(
    .NREQ(NREQ),
    .LAT (LAT),
    .IDW (IDW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .rdec   (rdec),
    .rdat   (rdat),
    .rkey   (rkey),
    .gnt    (gnt),
    .rsp_vld(rsp_vld),
    .rsp_id (rsp_id),
    .rsp_dat(rsp_dat),
    .rsp_rdy(rsp_rdy),
    .st     (st),
    .d      (d),
    .inp    (inp),
    .key    (key),
    .cout   (cout)
  );

  function automatic logic [63:0] rc(input int i);
    case (i)
      0:  return 64'h0000000000000000;
      1:  return 64'h13198a2e03707344;
      2:  return 64'ha4093822299f31d0;
      3:  return 64'h082efa98ec4e6c89;
      4:  return 64'h452821e638d01377;
      5:  return 64'hbe5466cf34e90c6c;
      6:  return 64'h7ef84f78fd955cb1;
      7:  return 64'h85840851f1ac43aa;
      8:  return 64'hc882d32f25323c54;
      9:  return 64'h64a51195e0e3610d;
      10: return 64'hd3b5a399ca0c2399;
      default: return 64'hc0ac29b7c97c50dd;
    endcase
  endfunction

  function automatic logic [3:0] sb(input logic [3:0] x, input bit inv);
    logic [63:0] t;
    t = inv ? 64'hb732fd89a6405ec1 : 64'hbf32ac916780e5d4;
    return t[63 - 4*int'(x) -: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s, input bit inv);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sb(s[4*n +: 4], inv);
    return r;
  endfunction

  // Bits numbered MSB-first; block (R,C) of M-hat is M_((R+C+sel)%4).
  function automatic logic [15:0] mhat(input logic [15:0] x, input int sel);
    logic [15:0] y;
    logic b;
    int blk, j, ex;
    for (int r = 0; r < 16; r++) begin
      blk = r / 4;
      j   = r % 4;
      ex  = (j - blk - sel + 8) % 4;
      b   = 1'b0;
      for (int c = 0; c < 4; c++) if (c != ex) b = b ^ x[15 - (4*c + j)];
      y[15 - r] = b;
    end
    return y;
  endfunction

  function automatic logic [63:0] mp(input logic [63:0] s);
    return {mhat(s[63:48], 0), mhat(s[47:32], 1), mhat(s[31:16], 1), mhat(s[15:0], 0)};
  endfunction

  function automatic logic [63:0] sr(input logic [63:0] s, input bit inv);
    logic [63:0] r;
    int p;
    for (int i = 0; i < 16; i++) begin
      p = 4*(((i / 4) + (i % 4)) % 4) + (i % 4);
      if (inv) r[63 - 4*p -: 4] = s[63 - 4*i -: 4];
      else     r[63 - 4*i -: 4] = s[63 - 4*p -: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] prince(input logic [63:0] blk, input logic [127:0] k, input logic dec);
    logic [63:0] k0, k0p, k1, t, s;
    k0  = k[127:64];
    k1  = k[63:0];
    k0p = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
    if (dec) begin
      t   = k0;
      k0  = k0p;
      k0p = t;
      k1  = k1 ^ 64'hc0ac29b7c97c50dd;
    end
    s = blk ^ k0 ^ k1 ^ rc(0);
    for (int i = 1; i <= 5; i++) s = sr(mp(s_layer(s, 1'b0)), 1'b0) ^ rc(i) ^ k1;
    s = s_layer(mp(s_layer(s, 1'b0)), 1'b1);
    for (int i = 6; i <= 10; i++) s = s_layer(mp(sr(s ^ k1 ^ rc(i), 1'b1)), 1'b1);
    return s ^ rc(11) ^ k1 ^ k0p;
  endfunction

  // Core model: result valid only in the LAT-th cycle after st, and only if
  // key/direction stayed put for the whole operation.
  logic [63:0]  pc_res;
  logic [127:0] pc_key;
  logic         pc_d;
  logic         pc_bad;
  int unsigned  pc_cnt;

  always @(posedge clk) begin
    if (rst) begin
      pc_cnt <= 0;
      pc_bad <= 1'b0;
    end else if (st) begin
      pc_res <= prince(inp, key, d);
      pc_key <= key;
      pc_d   <= d;
      pc_cnt <= 1;
      pc_bad <= 1'b0;
    end else if (pc_cnt != 0) begin
      pc_cnt <= pc_cnt + 1;
      if (key !== pc_key || d !== pc_d) pc_bad <= 1'b1;
    end
  end

  assign cout = (pc_cnt == LAT && !pc_bad) ? pc_res : ~pc_res;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input int unsigned i, input logic dec, input logic [63:0] dat, input logic [127:0] k);
    rdec[i]            = dec;
    rdat[64*i +: 64]   = dat;
    rkey[128*i +: 128] = k;
    req[i]             = 1'b1;
    #1;
  endtask

  task automatic wait_gnt(output int unsigned n);
    n = 0;
    while (gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Entered while gnt is visible; follows the operation up to rsp_vld.
  task automatic serve(input string tag, input int unsigned i, input logic [63:0] exp,
                       input logic [NREQ-1:0] drop);
    int unsigned cyc, stc, gc;
    check({tag, " gnt"}, 128'(gnt), 128'(1 << i));
    if (drop != '0) begin
      @(posedge clk);
      #1 req = req & ~drop;
    end
    cyc = 0;
    stc = 0;
    gc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (st) stc++;
      if (gnt != '0) gc++;
    end while (!rsp_vld && cyc < 60);
    check({tag, " latency"}, 128'(cyc), 128'(LAT + 2));
    check({tag, " st pulses"}, 128'(stc), 128'(1));
    check({tag, " gnt while busy"}, 128'(gc), 128'(0));
    check({tag, " rsp_id"}, 128'(rsp_id), 128'(i));
    check({tag, " rsp_dat"}, 128'(rsp_dat), 128'(exp));
    if (rsp_rdy) begin
      @(negedge clk);
      check({tag, " drained"}, 128'(rsp_vld), 128'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " gnt"}, 128'(gnt), 128'(0));
    check({tag, " st"}, 128'(st), 128'(0));
    check({tag, " rsp_vld"}, 128'(rsp_vld), 128'(0));
    check({tag, " rsp_id"}, 128'(rsp_id), 128'(0));
    check({tag, " rsp_dat"}, 128'(rsp_dat), 128'(0));
    check({tag, " d"}, 128'(d), 128'(0));
    check({tag, " inp"}, 128'(inp), 128'(0));
    check({tag, " key"}, key, 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, w, bad;
    logic [63:0] t4_exp [4];
    logic [63:0] hold_dat;
    logic [IDW-1:0] hold_id;

    n_run   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req     = '0;
    rdec    = '0;
    rdat    = '0;
    rkey    = '0;
    rsp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single requesters, encrypt / decrypt against known PRINCE vectors.
    rsp_rdy = 1'b1;
    drive(0, 1'b0, 64'h0000000000000000, 128'h0);
    wait_gnt(n);
    serve("t1", 0, 64'h818665aa0d02dfda, 4'b0001);
    drive(2, 1'b0, 64'hffffffffffffffff, 128'h0);
    wait_gnt(n);
    serve("t2", 2, 64'h604ae6ca03c20ada, 4'b0100);
    drive(1, 1'b1, 64'h818665aa0d02dfda, 128'h0);
    wait_gnt(n);
    serve("t3", 1, 64'h0000000000000000, 4'b0010);

    // All four held: arbitration order, pointer wrap, one idle bubble.
    do_reset();
    rsp_rdy  = 1'b1;
    t4_exp[0] = 64'h818665aa0d02dfda;
    t4_exp[1] = 64'h0000000000000000;
    t4_exp[2] = 64'h604ae6ca03c20ada;
    t4_exp[3] = 64'h818665aa0d02dfda;
    drive(0, 1'b0, 64'h0000000000000000, 128'h0);
    drive(1, 1'b1, 64'h818665aa0d02dfda, 128'h0);
    drive(2, 1'b0, 64'hffffffffffffffff, 128'h0);
    drive(3, 1'b0, 64'h0000000000000000, 128'h0);
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      if (k > 0) check("t4 bubble", 128'(n), 128'(0));
`ifdef PRINCE_SCHED_PRIO_EN
      w = 0;
`else
      w = k % 4;
`endif
      serve("t4", w, t4_exp[w], (k == 4) ? 4'b1111 : 4'b0000);
    end

    // Back-pressure: response held, no grant until the consumer accepts.
    rsp_rdy = 1'b0;
    drive(1, 1'b1, 64'h818665aa0d02dfda, 128'h0);
    drive(2, 1'b0, 64'hffffffffffffffff, 128'h0);
    wait_gnt(n);
    serve("t5a", 1, 64'h0000000000000000, 4'b0010);
    hold_dat = rsp_dat;
    hold_id  = rsp_id;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_vld !== 1'b1 || rsp_dat !== hold_dat || rsp_id !== hold_id || gnt !== '0) bad++;
    end
    check("t5 hold", 128'(bad), 128'(0));
    rsp_rdy = 1'b1;
    wait_gnt(n);
    check("t5 gnt delay", 128'(n), 128'(1));
    serve("t5b", 2, 64'h604ae6ca03c20ada, 4'b0100);

    // Reset mid-operation (RUN, cnt=5), then serve again from the reset pointer.
    drive(3, 1'b1, 64'h818665aa0d02dfda, 128'h0);
    wait_gnt(n);
    check("t6 gnt", 128'(gnt), 128'(4'b1000));
    @(posedge clk);
    #1 req = '0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6 rst");
    rst = 1'b0;
    bad = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (rsp_vld !== 1'b0 || st !== 1'b0) bad++;
    end
    check("t6 discarded", 128'(bad), 128'(0));
    drive(3, 1'b0, 64'hffffffffffffffff, 128'h0);
    wait_gnt(n);
    serve("t6 again", 3, 64'h604ae6ca03c20ada, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
